bk_slot_xfer: RTL and testbench

- Multi-slot save-state sector sequencer. Moves one slot of 2^SECT_W consecutive 512-byte sectors between the mounted backup image (via the hps_io sd_rd/sd_wr/sd_ack handshake) and the core's state buffer.
- Parametrised successor of the fixed 4-slot/64-sector save/load logic. Adds configurable slot count and slot size, an ack timeout, abort on image loss, and done/error status.
- Sits between the OSD status bits and hps_io. sd_buff_addr/sd_buff_* are wired externally, using sect_idx as the upper buffer address bits.

---
 rtl/bk_slot_xfer.sv | 163 ++++++++++++++++
 tb/tb_bk_slot_xfer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_slot_xfer.sv
// Save-state slot sequencer: walks the 2^SECT_W sectors of one slot through the
// hps_io sd_rd/sd_wr/sd_ack handshake, with ack timeout and abort on image loss.
module bk_slot_xfer #(
   parameter int SLOT_W = 2,
   parameter int SECT_W = 6,
   parameter int LBA_W  = 32,
   parameter int TMO_W  = 24
)(
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              enable,
   input  logic              load_req,
   input  logic              save_req,
   input  logic [SLOT_W-1:0] slot,
   input  logic              sd_ack,
   output logic              sd_rd,
   output logic              sd_wr,
   output logic [LBA_W-1:0]  sd_lba,
   output logic [SECT_W-1:0] sect_idx,
   output logic              busy,
   output logic              loading,
   output logic              done,
   output logic              error
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;

   state_t             state_reg;
   logic               old_ld_reg;
   logic               old_sv_reg;
   logic               old_ack_reg;
   logic               armed_reg;
   logic               sd_rd_reg;
   logic               sd_wr_reg;
   logic               busy_reg;
   logic               loading_reg;
   logic               done_reg;
   logic               error_reg;
   logic [LBA_W-1:0]   lba_reg;
   logic [TMO_W-1:0]   tmo_cnt_reg;

   logic               ld_edge;
   logic               sv_edge;
   logic               ack_rise;
   logic               ack_fall;
   logic               tmo_hit;
   logic               last_sect;
   logic               abort;
   logic [LBA_W-1:0]   start_lba;
   logic [LBA_W-1:0]   next_lba;

   // armed_reg keeps a request that is already high when reset releases from
   // looking like a fresh edge: the first cycle only samples the inputs.
   assign ld_edge   = armed_reg & ~old_ld_reg & load_req & enable;
   assign sv_edge   = armed_reg & ~old_sv_reg & save_req & enable;
   assign ack_rise  = ~old_ack_reg & sd_ack;
   assign ack_fall  = old_ack_reg & ~sd_ack;
   assign tmo_hit   = &tmo_cnt_reg;
   assign last_sect = &lba_reg[SECT_W-1:0];
   assign abort     = ~enable | tmo_hit;

   always_comb begin
      start_lba = '0;
      start_lba[SLOT_W+SECT_W-1:SECT_W] = slot;
      next_lba = lba_reg;
      next_lba[SECT_W-1:0] = lba_reg[SECT_W-1:0] + SECT_W'(1);
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         old_ld_reg  <= 1'b0;
         old_sv_reg  <= 1'b0;
         old_ack_reg <= 1'b0;
         armed_reg   <= 1'b0;
         sd_rd_reg   <= 1'b0;
         sd_wr_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         loading_reg <= 1'b0;
         done_reg    <= 1'b0;
         error_reg   <= 1'b0;
         lba_reg     <= '0;
         tmo_cnt_reg <= '0;
      end else begin
         old_ld_reg  <= load_req & enable;
         old_sv_reg  <= save_req & enable;
         old_ack_reg <= sd_ack;
         armed_reg   <= 1'b1;
         done_reg    <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               // load wins when both edges land in the same cycle
               if (ld_edge | sv_edge) begin
                  busy_reg    <= 1'b1;
                  loading_reg <= ld_edge;
                  error_reg   <= 1'b0;
                  lba_reg     <= start_lba;
                  sd_rd_reg   <= ld_edge;
                  sd_wr_reg   <= ~ld_edge;
                  tmo_cnt_reg <= '0;
                  state_reg   <= ST_REQ;
               end
            end

            ST_REQ: begin
               if (abort) begin
                  sd_rd_reg   <= 1'b0;
                  sd_wr_reg   <= 1'b0;
                  busy_reg    <= 1'b0;
                  loading_reg <= 1'b0;
                  error_reg   <= 1'b1;
                  state_reg   <= ST_IDLE;
               end else if (ack_rise) begin
                  sd_rd_reg   <= 1'b0;
                  sd_wr_reg   <= 1'b0;
                  state_reg   <= ST_XFER;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
               end
            end

            ST_XFER: begin
               if (abort) begin
                  sd_rd_reg   <= 1'b0;
                  sd_wr_reg   <= 1'b0;
                  busy_reg    <= 1'b0;
                  loading_reg <= 1'b0;
                  error_reg   <= 1'b1;
                  state_reg   <= ST_IDLE;
               end else if (ack_fall) begin
                  if (last_sect) begin
                     busy_reg    <= 1'b0;
                     loading_reg <= 1'b0;
                     done_reg    <= 1'b1;
                     state_reg   <= ST_IDLE;
                  end else begin
                     lba_reg     <= next_lba;
                     sd_rd_reg   <= loading_reg;
                     sd_wr_reg   <= ~loading_reg;
                     tmo_cnt_reg <= '0;
                     state_reg   <= ST_REQ;
                  end
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
               end
            end

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign sd_rd    = sd_rd_reg;
   assign sd_wr    = sd_wr_reg;
   assign sd_lba   = lba_reg;
   assign sect_idx = lba_reg[SECT_W-1:0];
   assign busy     = busy_reg;
   assign loading  = loading_reg;
   assign done     = done_reg;
   assign error    = error_reg;

endmodule

// File: tb/tb_bk_slot_xfer.sv
// Bench for bk_slot_xfer: an ack responder drives the handshake, a monitor logs
// each new sector request, and every transfer is compared to the slot's LBA range.
module tb_bk_slot_xfer;
   localparam int SLOT_W = 2;
   localparam int SECT_W = 6;
   localparam int LBA_W  = 32;
   localparam int NSECT  = 64;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic              reset;
   logic              enable;
   logic              load_req;
   logic              save_req;
   logic [SLOT_W-1:0] slot;
   logic              sd_ack;
   logic              sd_rd;
   logic              sd_wr;
   logic [LBA_W-1:0]  sd_lba;
   logic [SECT_W-1:0] sect_idx;
   logic              busy;
   logic              loading;
   logic              done;
   logic              error;

   logic              en_t;
   logic              ld_t;
   logic              sv_t;
   logic [SLOT_W-1:0] slot_t;
   logic              ack_t;
   logic              sd_rd_t;
   logic              sd_wr_t;
   logic [LBA_W-1:0]  sd_lba_t;
   logic [SECT_W-1:0] sect_idx_t;
   logic              busy_t;
   logic              loading_t;
   logic              done_t;
   logic              error_t;

   int checks = 0;
   int failures = 0;

   int ack_dly = 5;
   int ack_hi = 3;
   bit rand_ack = 0;

   logic [LBA_W-1:0] req_lba_q[$];
   bit               req_dir_q[$];
   int               done_cnt = 0;
   bit               both_seen = 0;
   bit               idx_bad = 0;
   bit               prev_req = 0;

   bk_slot_xfer dut (
      .clk_sys(clk_sys), .reset(reset), .enable(enable),
      .load_req(load_req), .save_req(save_req), .slot(slot), .sd_ack(sd_ack),
      .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba), .sect_idx(sect_idx),
      .busy(busy), .loading(loading), .done(done), .error(error)
   );

   bk_slot_xfer #(.TMO_W(4)) dut_t (
      .clk_sys(clk_sys), .reset(reset), .enable(en_t),
      .load_req(ld_t), .save_req(sv_t), .slot(slot_t), .sd_ack(ack_t),
      .sd_rd(sd_rd_t), .sd_wr(sd_wr_t), .sd_lba(sd_lba_t), .sect_idx(sect_idx_t),
      .busy(busy_t), .loading(loading_t), .done(done_t), .error(error_t)
   );

   // Host model: after seeing a request, wait, then hold ack high for a while.
   initial begin
      int d;
      int h;
      sd_ack = 1'b0;
      forever begin
         @(negedge clk_sys);
         if ((sd_rd || sd_wr) && !sd_ack) begin
            d = rand_ack ? int'($urandom_range(1, 6)) : ack_dly;
            h = rand_ack ? int'($urandom_range(1, 4)) : ack_hi;
            repeat (d) @(negedge clk_sys);
            sd_ack = 1'b1;
            repeat (h) @(negedge clk_sys);
            sd_ack = 1'b0;
            @(negedge clk_sys);
         end
      end
   end

   always @(negedge clk_sys) begin
      if ((sd_rd || sd_wr) && !prev_req) begin
         req_lba_q.push_back(sd_lba);
         req_dir_q.push_back(sd_rd);
      end
      prev_req = sd_rd || sd_wr;
      if (sd_rd && sd_wr) both_seen = 1;
      if (done) done_cnt++;
      if (sect_idx !== sd_lba[SECT_W-1:0]) idx_bad = 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_xfer(input bit is_load, input bit both, input logic [SLOT_W-1:0] s);
      req_lba_q.delete();
      req_dir_q.delete();
      done_cnt = 0;
      both_seen = 0;
      idx_bad = 0;
      slot = s;
      if (is_load || both) load_req = 1'b1;
      if (!is_load || both) save_req = 1'b1;
      @(negedge clk_sys);
      chk("start_ctrl", {busy, loading, sd_rd, sd_wr, error}, {1'b1, is_load, is_load, !is_load, 1'b0});
      chk("start_lba", sd_lba, LBA_W'(s) * 64);
   endtask

   task automatic finish_xfer(input bit is_load, input logic [SLOT_W-1:0] s, input string tag);
      int n = 0;
      int bad = -1;
      while (done_cnt == 0 && n < 4000) begin
         @(negedge clk_sys);
         n++;
      end
      chk({tag, "_done_seen"}, done_cnt != 0, 1'b1);
      repeat (3) @(negedge clk_sys);
      if (req_lba_q.size() == NSECT)
         for (int i = 0; i < NSECT; i++)
            if (bad < 0 && (req_lba_q[i] !== LBA_W'(s) * 64 + LBA_W'(i) || req_dir_q[i] !== is_load))
               bad = i;
      chk({tag, "_req_count"}, req_lba_q.size(), NSECT);
      chk({tag, "_req_seq"}, bad, -1);
      chk({tag, "_done_pulse"}, done_cnt, 1);
      chk({tag, "_end_state"}, {busy, loading, error, both_seen, idx_bad}, 5'b0);
      $display("xfer %s dir=%s slot=%0d reqs=%0d first_bad=%0d dones=%0d",
               tag, is_load ? "load" : "save", s, req_lba_q.size(), bad, done_cnt);
   endtask

   initial begin
      int n;
      bit dir;
      logic [SLOT_W-1:0] rs;

      reset = 1'b1; enable = 1'b1; load_req = 1'b0; save_req = 1'b0; slot = '0;
      en_t = 1'b1; ld_t = 1'b0; sv_t = 1'b0; slot_t = '0; ack_t = 1'b0;
      repeat (2) @(negedge clk_sys);
      chk("reset_outs", {sd_rd, sd_wr, busy, loading, done, error, sd_lba, sect_idx}, '0);
      chk("reset_outs_t", {sd_rd_t, sd_wr_t, busy_t, loading_t, done_t, error_t, sd_lba_t}, '0);
      reset = 1'b0;
      repeat (2) @(negedge clk_sys);

      // slot 2 load with fixed 5/3 ack timing
      start_xfer(1, 0, 2);
      finish_xfer(1, 2, "load_s2");
      load_req = 1'b0;
      @(negedge clk_sys);

      start_xfer(0, 0, 3);
      finish_xfer(0, 3, "save_s3");
      save_req = 1'b0;
      @(negedge clk_sys);

      // simultaneous edges: load wins; a save edge while busy is dropped
      start_xfer(1, 1, 1);
      repeat (20) @(negedge clk_sys);
      save_req = 1'b0;
      @(negedge clk_sys);
      save_req = 1'b1;
      finish_xfer(1, 1, "both_edges");
      load_req = 1'b0; save_req = 1'b0;
      @(negedge clk_sys);

      // image loss at sector 140
      start_xfer(1, 0, 2);
      n = 0;
      while (sd_lba != 140 && n < 3000) begin
         @(negedge clk_sys);
         n++;
      end
      chk("lba140_reached", sd_lba, 140);
      enable = 1'b0;
      @(negedge clk_sys);
      chk("abort_ctrl", {sd_rd, sd_wr, busy, loading, done, error}, 6'b000001);
      chk("abort_lba", sd_lba, 140);
      done_cnt = 0;
      repeat (20) @(negedge clk_sys);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_err_sticky", error, 1'b1);
      $display("xfer abort lba=%0d error=%0d dones=%0d", sd_lba, error, done_cnt);
      load_req = 1'b0;
      enable = 1'b1;
      repeat (2) @(negedge clk_sys);
      start_xfer(1, 0, 2);
      finish_xfer(1, 2, "after_abort");
      load_req = 1'b0;
      @(negedge clk_sys);

      // timeout instance never sees an ack: 1 request cycle + 15 counting cycles
      ld_t = 1'b1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_sys);
         if (sd_rd_t) n++;
         else break;
      end
      chk("tmo_req_cycles", n, 16);
      chk("tmo_state", {sd_rd_t, sd_wr_t, busy_t, loading_t, done_t, error_t}, 6'b000001);
      $display("xfer timeout req_cycles=%0d error=%0d", n, error_t);
      ld_t = 1'b0;

      // async reset mid-transfer with load_req held high
      start_xfer(1, 0, 0);
      repeat (50) @(negedge clk_sys);
      @(posedge clk_sys);
      #2 reset = 1'b1;
      #1 chk("async_reset_outs", {sd_rd, sd_wr, busy, loading, done, error, sd_lba, sect_idx}, '0);
      repeat (2) @(negedge clk_sys);
      #2 reset = 1'b0;
      repeat (10) @(negedge clk_sys);
      chk("held_req_no_start", {busy, sd_rd, sd_wr}, 3'b000);
      $display("xfer reset_mid busy=%0d", busy);
      repeat (10) @(negedge clk_sys);
      load_req = 1'b0;
      @(negedge clk_sys);
      start_xfer(1, 0, 0);
      finish_xfer(1, 0, "after_reset");
      load_req = 1'b0;
      @(negedge clk_sys);

      // randomized slots, directions and ack timing
      rand_ack = 1;
      for (int k = 0; k < 3; k++) begin
         rs = SLOT_W'($urandom_range(0, 3));
         dir = 1'($urandom_range(0, 1));
         start_xfer(dir, 0, rs);
         finish_xfer(dir, rs, "random");
         load_req = 1'b0; save_req = 1'b0;
         repeat (2) @(negedge clk_sys);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
